// File: rtl/tdes_ahb_master_if.sv
// AHB-Lite bus bundle between the 3DES sequencer and its memory-mapped slave.
interface tdes_ahb_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/tdes_ahb_master.sv
// AHB-Lite master that drives one 3DES operation on a slave engine:
// load keys/data, kick control, poll status, then fetch the result.
module tdes_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_MAX  = 255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        encrypt,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] result,
    tdes_ahb_master_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_POLL_WAIT = 3'd3;
    localparam logic [2:0] S_ERR       = 3'd4;

    localparam logic [2:0] W_KEY1   = 3'd0;
    localparam logic [2:0] W_KEY2   = 3'd1;
    localparam logic [2:0] W_KEY3   = 3'd2;
    localparam logic [2:0] W_DATA   = 3'd3;
    localparam logic [2:0] W_CTRL   = 3'd4;
    localparam logic [2:0] R_STATUS = 3'd5;
    localparam logic [2:0] R_RESULT = 3'd6;

    localparam int PW = $clog2(POLL_MAX + 2);

    logic [2:0]    state;
    logic [2:0]    step;
    logic [PW-1:0] poll_cnt;
    logic [PW-1:0] poll_nxt;
    logic          enc_q;
    logic [63:0]   k1_q, k2_q, k3_q, d_q;
    logic [63:0]   wdata;
    logic          in_xfer;

    assign poll_nxt = poll_cnt + PW'(1);
    assign in_xfer  = (state == S_ADDR) || (state == S_DATA);

    // Step index doubles as the register offset: offset = step * 8.
    always_comb begin
        wdata = '0;
        unique case (step)
            W_KEY1:  wdata = k1_q;
            W_KEY2:  wdata = k2_q;
            W_KEY3:  wdata = k3_q;
            W_DATA:  wdata = d_q;
            W_CTRL:  wdata = {63'd0, enc_q};
            default: wdata = '0;
        endcase
    end

    assign bus.HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign bus.HADDR     = in_xfer ? BASE_ADDR + {26'd0, step, 3'd0} : '0;
    assign bus.HWRITE    = in_xfer && (step < R_STATUS);
    assign bus.HWDATA    = (state == S_DATA && bus.HWRITE) ? wdata : '0;
    assign bus.HSIZE     = 3'b011;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign error         = (state == S_ERR);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= S_IDLE;
            step     <= W_KEY1;
            poll_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            enc_q    <= 1'b0;
            k1_q     <= '0;
            k2_q     <= '0;
            k3_q     <= '0;
            d_q      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        enc_q    <= encrypt;
                        k1_q     <= key1;
                        k2_q     <= key2;
                        k3_q     <= key3;
                        d_q      <= data_in;
                        busy     <= 1'b1;
                        step     <= W_KEY1;
                        poll_cnt <= '0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.HREADY) state <= S_DATA;
                end
                S_DATA: begin
                    if (bus.HREADY) begin
                        if (bus.HRESP) begin
                            busy  <= 1'b0;
                            state <= S_ERR;
                        end else if (step == R_STATUS) begin
                            if (bus.HRDATA[0]) begin
                                step  <= R_RESULT;
                                state <= S_ADDR;
                            end else if (poll_nxt >= PW'(POLL_MAX)) begin
                                poll_cnt <= poll_nxt;
                                busy     <= 1'b0;
                                state    <= S_ERR;
                            end else begin
                                poll_cnt <= poll_nxt;
                                state    <= S_POLL_WAIT;
                            end
                        end else if (step == R_RESULT) begin
                            result <= bus.HRDATA;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_ADDR;
                        end
                    end
                end
                S_POLL_WAIT: state <= S_ADDR;
                S_ERR:       state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdes_ahb_master.sv
// Scoreboard bench: a reference model predicts every AHB transfer and the
// done/error outcome of each operation; monitors compare what the DUT does.
module tb_tdes_ahb_master;
    localparam logic [31:0] BASE   = 32'h4000_0100;
    localparam int          PMAX   = 4;
    localparam logic [31:0] A_STAT = BASE + 32'h28;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [63:0] wd;
    } xfer_t;

    typedef struct {
        logic        is_err;
        logic [63:0] res;
    } out_t;

    logic        HCLK    = 1'b0;
    logic        HRESET  = 1'b0;
    logic        start   = 1'b0;
    logic        encrypt = 1'b0;
    logic [63:0] key1    = '0;
    logic [63:0] key2    = '0;
    logic [63:0] key3    = '0;
    logic [63:0] data_in = '0;
    logic        busy, done, error;
    logic [63:0] result;

    tdes_ahb_master_if bus();

    tdes_ahb_master #(
        .BASE_ADDR(BASE),
        .POLL_MAX (PMAX)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .start  (start),
        .encrypt(encrypt),
        .key1   (key1),
        .key2   (key2),
        .key3   (key3),
        .data_in(data_in),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int passed = 0;

    xfer_t exp_tr[$];
    out_t  exp_out[$];

    logic        op_enc;
    logic [63:0] op_k1, op_k2, op_k3, op_d;
    int          cfg_wait[7];
    int          cfg_err;
    int          cfg_polls;
    logic [63:0] cfg_res;
    logic [63:0] model_last = '0;
    bit          last_err   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // Reference model: the register-level story of one operation.
    task automatic model_push();
        logic [63:0] wd[5];
        xfer_t       x;
        out_t        o;
        bit          got;
        wd[0] = op_k1;
        wd[1] = op_k2;
        wd[2] = op_k3;
        wd[3] = op_d;
        wd[4] = {63'd0, op_enc};
        o.is_err = 1'b1;
        o.res    = model_last;
        last_err = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x.addr = BASE + 32'(i * 8);
            x.wr   = 1'b1;
            x.wd   = wd[i];
            exp_tr.push_back(x);
            if (cfg_err == i) begin
                exp_out.push_back(o);
                return;
            end
        end
        got = 1'b0;
        for (int p = 0; p < PMAX && !got; p++) begin
            x.addr = A_STAT;
            x.wr   = 1'b0;
            x.wd   = '0;
            exp_tr.push_back(x);
            if (cfg_err == 5 && p == 0) begin
                exp_out.push_back(o);
                return;
            end
            if (p == cfg_polls) got = 1'b1;
        end
        if (!got) begin
            exp_out.push_back(o);
            return;
        end
        x.addr = BASE + 32'h30;
        x.wr   = 1'b0;
        x.wd   = '0;
        exp_tr.push_back(x);
        if (cfg_err == 6) begin
            exp_out.push_back(o);
            return;
        end
        o.is_err   = 1'b0;
        o.res      = cfg_res;
        model_last = cfg_res;
        last_err   = 1'b0;
        exp_out.push_back(o);
    endtask

    // Slave: serves the register map with configurable waits/errors.
    initial begin
        bit          s_data;
        int          s_wait, s_idx, st_cnt;
        s_data = 1'b0;
        s_wait = 0;
        s_idx  = 0;
        st_cnt = 0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                s_data     = 1'b0;
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
            end else if (s_data) begin
                if (s_wait > 0) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = 1'b0;
                    s_wait--;
                end else begin
                    bus.HREADY = 1'b1;
                    s_data     = 1'b0;
                    bus.HRESP  = (s_idx == cfg_err) &&
                                 (s_idx != 5 || st_cnt == 0);
                    bus.HRDATA = {$urandom, $urandom};
                    if (s_idx == 5) begin
                        bus.HRDATA[0] = (st_cnt == cfg_polls);
                        st_cnt++;
                    end else if (s_idx == 6) begin
                        bus.HRDATA = cfg_res;
                    end
                end
            end else begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
                if (bus.HTRANS == 2'b10) begin
                    s_data = 1'b1;
                    s_idx  = int'((bus.HADDR - BASE) >> 3);
                    if (s_idx < 0 || s_idx > 6) s_idx = 0;
                    if (s_idx == 0) st_cnt = 0;
                    s_wait = cfg_wait[s_idx];
                end
            end
        end
    end

    // Transfer monitor.
    initial begin
        bit          m_pend, m_post;
        logic [31:0] m_addr;
        logic        m_wr;
        logic [63:0] m_wd;
        int          m_dc;
        xfer_t       e;
        m_pend = 1'b0;
        m_post = 1'b0;
        m_addr = '0;
        m_wr   = 1'b0;
        m_wd   = '0;
        m_dc   = 0;
        forever begin
            @(negedge HCLK);
            #1;
            if (HRESET) begin
                m_pend = 1'b0;
                m_post = 1'b0;
            end else begin
                if (m_post) begin
                    chk("poll_wait_idle", 64'(bus.HTRANS), 64'd0);
                    m_post = 1'b0;
                end
                if (m_pend) begin
                    chk("data_htrans", 64'(bus.HTRANS), 64'd0);
                    if (!bus.HREADY) begin
                        chk("hold_haddr", 64'(bus.HADDR), 64'(m_addr));
                        if (m_dc == 0) m_wd = bus.HWDATA;
                        else chk("hold_hwdata", bus.HWDATA, m_wd);
                        m_dc++;
                    end else begin
                        if (exp_tr.size() == 0) begin
                            fail("unexpected_xfer", "extra transfer, expected none");
                        end else begin
                            e = exp_tr.pop_front();
                            chk("xfer_addr", 64'(m_addr), 64'(e.addr));
                            chk("xfer_write", 64'(m_wr), 64'(e.wr));
                            if (e.wr) chk("xfer_wdata", bus.HWDATA, e.wd);
                        end
                        if (!m_wr && m_addr == A_STAT &&
                            !bus.HRESP && !bus.HRDATA[0]) m_post = 1'b1;
                        m_pend = 1'b0;
                    end
                end else if (bus.HTRANS == 2'b10 && bus.HREADY) begin
                    m_pend = 1'b1;
                    m_addr = bus.HADDR;
                    m_wr   = bus.HWRITE;
                    m_dc   = 0;
                    chk("ctrl_const",
                        64'({bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}),
                        64'({3'b011, 3'b000, 4'b0011, 1'b0}));
                end
            end
        end
    end

    // Outcome monitor.
    initial begin
        out_t o;
        forever begin
            @(negedge HCLK);
            #1;
            if (!HRESET && (done || error)) begin
                if (exp_out.size() == 0) begin
                    fail("unexpected_pulse", "done/error pulse, expected none");
                end else begin
                    o = exp_out.pop_front();
                    chk("pulse_kind", 64'({done, error}),
                        o.is_err ? 64'd1 : 64'd2);
                    chk("result", result, o.res);
                    chk("busy_clear", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < 7; i++) cfg_wait[i] = 0;
        cfg_err   = -1;
        cfg_polls = 0;
        cfg_res   = {$urandom, $urandom};
        op_enc    = 1'($urandom_range(0, 1));
        op_k1     = {$urandom, $urandom};
        op_k2     = {$urandom, $urandom};
        op_k3     = {$urandom, $urandom};
        op_d      = {$urandom, $urandom};
    endtask

    task automatic rand_cfg();
        clear_cfg();
        for (int i = 0; i < 7; i++) cfg_wait[i] = int'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) cfg_err = int'($urandom_range(0, 6));
        cfg_polls = int'($urandom_range(0, 5));
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        exp_tr.delete();
        exp_out.delete();
        model_last = '0;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic issue(input bit b2b);
        if (!b2b) begin
            @(negedge HCLK);
            #2;
        end
        model_push();
        start   = 1'b1;
        encrypt = op_enc;
        key1    = op_k1;
        key2    = op_k2;
        key3    = op_k3;
        data_in = op_d;
        @(posedge HCLK);
        #1;
        start   = 1'b0;
        encrypt = ~op_enc;
        key1    = {$urandom, $urandom};
        key2    = {$urandom, $urandom};
        key3    = {$urandom, $urandom};
        data_in = {$urandom, $urandom};
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            @(negedge HCLK);
            #2;
            if (exp_out.size() == 0) begin
                chk("xfers_left", 64'(exp_tr.size()), 64'd0);
                return;
            end
        end
        fail("op_timeout", "no done/error pulse, expected one");
        do_reset();
    endtask

    task automatic run_op(input bit b2b, input int busy_pulse);
        issue(b2b);
        if (busy_pulse > 0) begin
            repeat (busy_pulse) @(posedge HCLK);
            #1;
            chk("busy_before_pulse", 64'(busy), 64'd1);
            start = 1'b1;
            @(posedge HCLK);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        bit found;
        clear_cfg();
        #2 HRESET = 1'b1;
        #1;
        chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("rst_haddr", 64'(bus.HADDR), 64'd0);
        chk("rst_flags", 64'({busy, done, error, bus.HWRITE}), 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        clear_cfg();
        op_enc    = 1'b1;
        op_k1     = 64'h0123456789ABCDEF;
        op_k2     = 64'h0123456789ABCDEF;
        op_k3     = 64'h0123456789ABCDEF;
        op_d      = 64'h4E6F772069732074;
        cfg_polls = 2;
        run_op(1'b0, 0);

        clear_cfg();
        op_enc      = 1'b0;
        cfg_wait[1] = 3;
        cfg_polls   = 1;
        run_op(1'b0, 0);

        clear_cfg();
        cfg_err = 3;
        run_op(1'b0, 0);

        clear_cfg();
        cfg_polls = 100;
        run_op(1'b0, 0);

        clear_cfg();
        cfg_polls = 2;
        run_op(1'b0, 4);

        clear_cfg();
        cfg_wait[6] = 1;
        run_op(1'b0, 0);
        clear_cfg();
        run_op(1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            bit b2b;
            b2b = !last_err && ($urandom_range(0, 1) == 1);
            rand_cfg();
            run_op(b2b, (cfg_err < 0 && $urandom_range(0, 2) == 0) ? 3 : 0);
        end

        clear_cfg();
        cfg_polls = 3;
        issue(1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge HCLK);
            #2;
            if (bus.HTRANS == 2'b10 && bus.HADDR == A_STAT) found = 1'b1;
        end
        if (!found) fail("status_seen", "no status read, expected one");
        #1 HRESET = 1'b1;
        #1;
        chk("mid_rst_htrans", 64'(bus.HTRANS), 64'd0);
        chk("mid_rst_haddr", 64'(bus.HADDR), 64'd0);
        chk("mid_rst_hwdata", bus.HWDATA, 64'd0);
        chk("mid_rst_flags", 64'({busy, done, error, bus.HWRITE}), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        exp_tr.delete();
        exp_out.delete();
        model_last = '0;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        clear_cfg();
        cfg_polls = 1;
        run_op(1'b0, 0);

        repeat (3) @(negedge HCLK);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tdes_ahb_master.md
TDES_AHB_MASTER -- requirements
Module: tdes_ahb_master

Interface
REQ-001 SHALL have ports: HCLK  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: HRESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle request to run one 3DES operation.
REQ-004 SHALL have ports: encrypt  in  1  1=encrypt, 0=decrypt; sampled with start.
REQ-005 SHALL have ports: key1, key2, key3, data_in  in  64 each  operands; sampled with start.
REQ-006 SHALL have ports: busy  out  1 (operation in progress); done  out  1 (one-cycle completion pulse); error  out  1 (one-cycle failure pulse); result  out  64 (last good result).
REQ-007 SHALL have ports: HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HMASTLOCK  out  1; HWDATA  out  64.
REQ-008 SHALL have ports: HREADY  in  1; HRESP  in  1; HRDATA  in  64.
REQ-009 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning slave base address.
REQ-010 SHALL have parameter POLL_MAX, default 255, meaning status polls before timeout.

Function
REQ-011 SHALL drive a fixed slave register map at BASE_ADDR offsets: 0x00 key1, 0x08 key2, 0x10 key3, 0x18 data, 0x20 control (write; bit0=encrypt, starts slave), 0x28 status (read; bit0=done), 0x30 result (read).
REQ-012 SHALL drive constants on every transfer: HSIZE=3'b011, HBURST=3'b000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
REQ-013 SHALL use non-pipelined single transfers: address phase HTRANS=2'b10 (NONSEQ) for one cycle; data phase with HTRANS=2'b00 (IDLE) until HREADY=1.
REQ-014 SHALL hold HADDR/HWRITE in the address phase until HREADY=1 is sampled, and hold HWDATA stable through the whole data phase.
REQ-015 SHALL use states IDLE, ADDR, DATA, POLL_WAIT, ERR.
REQ-016 SHALL sequence steps in order: W_KEY1, W_KEY2, W_KEY3, W_DATA, W_CTRL, R_STATUS (repeated), R_RESULT; a step index register selects the address/data.
REQ-017 SHALL in IDLE with start=1 latch encrypt, keys and data_in, set busy=1, step=W_KEY1, and go to ADDR next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL on completion of a write data phase (HREADY=1, HRESP=0) advance step and return to ADDR.
REQ-020 SHALL on completion of R_STATUS with HRDATA[0]=1 go to R_RESULT.
REQ-021 SHALL on completion of R_STATUS with HRDATA[0]=0 increment poll counter, spend one cycle in POLL_WAIT (HTRANS IDLE), then reissue R_STATUS.
REQ-022 SHALL, if the poll counter reaches POLL_MAX without done, enter ERR.
REQ-023 SHALL on completion of R_RESULT load result<=HRDATA, pulse done for one cycle, clear busy, and return to IDLE, so that start accepted in the following cycle is honored.
REQ-024 SHALL treat HRESP=1 sampled in any data phase as an error and enter ERR without completing remaining steps; result is unchanged.
REQ-025 SHALL in ERR drive HTRANS IDLE, pulse error for one cycle, clear busy, and go to IDLE next cycle.
REQ-026 SHALL clear the poll counter at each accepted start.
REQ-027 SHALL drive HTRANS=2'b00 in IDLE, POLL_WAIT and ERR.

Reset
REQ-028 SHALL, while HRESET=1, immediately force state=IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, result=0, step and poll counter=0.
REQ-029 SHALL on reset mid-transfer abandon the transfer with no completion or error pulse; first start after release begins at W_KEY1.

Verification
REQ-030 SHALL be verified by: encrypt start with key1=key2=key3=64'h0123456789ABCDEF, data 64'h4E6F772069732074, zero-wait slave done after 2 polls -> five writes at 0x00..0x20 in order with correct HWDATA, control HWDATA bit0=1, 3 status reads, one result read, done pulse 1 cycle, result=slave value.
REQ-031 SHALL be verified by: slave inserting 3 wait states (HREADY=0) on W_KEY2 -> HADDR/HWDATA stable during the wait, no step skipped, sequence completes.
REQ-032 SHALL be verified by: HRESP=1 on W_DATA -> error pulse, no W_CTRL issued, busy=0 next cycle, result unchanged.
REQ-033 SHALL be verified by: status never done, POLL_MAX=4 -> exactly 4 status reads then error pulse, no result read.
REQ-034 SHALL be verified by: start pulsed while busy -> ignored; HRESET asserted during R_STATUS -> all outputs at reset values asynchronously, new start after release restarts at 0x00.
